// File: rtl/const_bank_pkg.sv
// Shared constants and helpers for the configuration constant bank.
// Holds the width ceiling and the shift-counter width function.
package const_bank_pkg;

  localparam int CONST_BANK_MAX_WIDTH = 64;

  // Counter must hold 0..width inclusive
  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/const_bank_chain.sv
// Serial shadow chain for const_bank: shift register plus
// saturating shift counter that reports when a full word is in.
module const_bank_chain
  import const_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = count_w(WIDTH)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             ccff_head,
  input  logic             shift_en,
  input  logic             clr,
  output logic [WIDTH-1:0] shadow,
  output logic [CW-1:0]    count,
  output logic             loaded,
  output logic             ccff_tail
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;

  assign full = (count_q == CW'(WIDTH));

  // Next shadow: new bit enters at the top, bit 0 falls out the tail
  always_comb begin
    shadow_d = shadow_q;
    if (shift_en) begin
      shadow_d[WIDTH-1] = ccff_head;
      for (int i = 0; i < WIDTH - 1; i++) begin
        shadow_d[i] = shadow_q[i + 1];
      end
    end
  end

  // Next count: cleared by an accepted commit, saturates at WIDTH
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = shift_en ? CW'(1) : '0;
    end else if (shift_en && !full) begin
      count_d = count_q + CW'(1);
    end
  end

  // Chain state registers
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign shadow    = shadow_q;
  assign count     = count_q;
  assign loaded    = full;
  assign ccff_tail = shadow_q[0];

endmodule

// File: rtl/const_bank.sv
// Configurable tie-off constant bank. Bits are shifted into a shadow
// chain and only reach const_out on a commit of a complete word.
module const_bank
  import const_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             ccff_head,
  input  logic             shift_en,
  input  logic             commit,
  output logic [WIDTH-1:0] const_out,
  output logic             ccff_tail,
  output logic             loaded,
  output logic             cfg_valid,
  output logic             commit_err
);

  localparam int CW = count_w(WIDTH);

  if (WIDTH < 1 || WIDTH > CONST_BANK_MAX_WIDTH) begin : g_bad_width
    $error("const_bank: WIDTH out of range");
  end

  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    count;
  logic             accept;

  logic [WIDTH-1:0] const_out_q, const_out_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             commit_err_q, commit_err_d;

  assign accept = commit & loaded;

  const_bank_chain #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_chain (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .clr       (accept),
    .shadow    (shadow),
    .count     (count),
    .loaded    (loaded),
    .ccff_tail (ccff_tail)
  );

  // Commit transfers the pre-edge shadow; a premature commit only flags
  always_comb begin
    const_out_d  = const_out_q;
    cfg_valid_d  = cfg_valid_q;
    commit_err_d = commit_err_q;
    if (accept) begin
      const_out_d = shadow;
      cfg_valid_d = 1'b1;
    end else if (commit) begin
      commit_err_d = 1'b1;
    end
  end

  // Output registers; const_out only moves on accepted commit or reset
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      const_out_q  <= RESET_VAL;
      cfg_valid_q  <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      const_out_q  <= const_out_d;
      cfg_valid_q  <= cfg_valid_d;
      commit_err_q <= commit_err_d;
    end
  end

  assign const_out  = const_out_q;
  assign cfg_valid  = cfg_valid_q;
  assign commit_err = commit_err_q;

endmodule

// File: tb/tb_const_bank.sv
// Self-checking bench for const_bank (WIDTH=8, RESET_VAL=0x3C).
// Hand-derived vector table applied through a scoreboard queue.
module tb_const_bank;

  logic       clk = 1'b0;
  logic       pReset = 1'b1;
  logic       ccff_head = 1'b0;
  logic       shift_en = 1'b0;
  logic       commit = 1'b0;
  logic [7:0] const_out;
  logic       ccff_tail;
  logic       loaded;
  logic       cfg_valid;
  logic       commit_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  const_bank #(
    .WIDTH     (8),
    .RESET_VAL (8'h3C)
  ) dut (
    .prog_clk   (clk),
    .pReset     (pReset),
    .ccff_head  (ccff_head),
    .shift_en   (shift_en),
    .commit     (commit),
    .const_out  (const_out),
    .ccff_tail  (ccff_tail),
    .loaded     (loaded),
    .cfg_valid  (cfg_valid),
    .commit_err (commit_err)
  );

  typedef struct {
    logic       rst;
    logic       sh;
    logic       hd;
    logic       cm;
    logic [7:0] e_out;
    logic       e_v;
    logic       e_err;
    logic [7:0] e_sh;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic void add(
    input logic rst, input logic sh, input logic hd, input logic cm,
    input logic [7:0] out, input logic v, input logic err,
    input logic [7:0] shd, input logic [3:0] cnt);
    vec_t t;
    t.rst = rst; t.sh = sh; t.hd = hd; t.cm = cm;
    t.e_out = out; t.e_v = v; t.e_err = err;
    t.e_sh = shd; t.e_cnt = cnt;
    tbl.push_back(t);
  endfunction

  task automatic cmp(input int id, input string nm,
                     input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s got %h want %h", id, nm, got, want);
    end
  endtask

  task automatic check(input vec_t e, input int id);
    cmp(id, "const_out", const_out, e.e_out);
    cmp(id, "cfg_valid", {7'd0, cfg_valid}, {7'd0, e.e_v});
    cmp(id, "commit_err", {7'd0, commit_err}, {7'd0, e.e_err});
    cmp(id, "loaded", {7'd0, loaded}, {7'd0, (e.e_cnt == 4'd8)});
    cmp(id, "ccff_tail", {7'd0, ccff_tail}, {7'd0, e.e_sh[0]});
    cmp(id, "count", {4'd0, dut.u_chain.count}, {4'd0, e.e_cnt});
    cmp(id, "shadow", dut.u_chain.shadow, e.e_sh);
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    if (v.rst) begin
      shift_en = 1'b0;
      commit   = 1'b0;
      pReset   = 1'b1;
      sb.push_back(v);
      #1;
      check(sb.pop_front(), id);
      #1;
      pReset = 1'b0;
    end else begin
      shift_en  = v.sh;
      ccff_head = v.hd;
      commit    = v.cm;
      sb.push_back(v);
      @(posedge clk);
      #1;
      check(sb.pop_front(), id);
      shift_en = 1'b0;
      commit   = 1'b0;
    end
  endtask

  initial begin
    vec_t h;
    // rst sh hd cm out v err shadow cnt
    // premature commit after 3 shifts
    add(1, 0, 0, 0, 8'h3C, 0, 0, 8'h00, 0);
    add(0, 1, 1, 0, 8'h3C, 0, 0, 8'h80, 1);
    add(0, 1, 1, 0, 8'h3C, 0, 0, 8'hC0, 2);
    add(0, 1, 0, 0, 8'h3C, 0, 0, 8'h60, 3);
    add(0, 0, 0, 1, 8'h3C, 0, 1, 8'h60, 3);
    // load 1,0,1,0,0,1,0,1 and commit -> 0xA5
    add(1, 0, 0, 0, 8'h3C, 0, 0, 8'h00, 0);
    add(0, 1, 1, 0, 8'h3C, 0, 0, 8'h80, 1);
    add(0, 1, 0, 0, 8'h3C, 0, 0, 8'h40, 2);
    add(0, 1, 1, 0, 8'h3C, 0, 0, 8'hA0, 3);
    add(0, 1, 0, 0, 8'h3C, 0, 0, 8'h50, 4);
    add(0, 1, 0, 0, 8'h3C, 0, 0, 8'h28, 5);
    add(0, 1, 1, 0, 8'h3C, 0, 0, 8'h94, 6);
    add(0, 1, 0, 0, 8'h3C, 0, 0, 8'h4A, 7);
    add(0, 1, 1, 0, 8'h3C, 0, 0, 8'hA5, 8);
    add(0, 0, 0, 1, 8'hA5, 1, 0, 8'hA5, 0);
    // reload same pattern; const_out must hold
    add(0, 1, 1, 0, 8'hA5, 1, 0, 8'hD2, 1);
    add(0, 1, 0, 0, 8'hA5, 1, 0, 8'h69, 2);
    add(0, 1, 1, 0, 8'hA5, 1, 0, 8'hB4, 3);
    add(0, 1, 0, 0, 8'hA5, 1, 0, 8'h5A, 4);
    add(0, 1, 0, 0, 8'hA5, 1, 0, 8'h2D, 5);
    add(0, 1, 1, 0, 8'hA5, 1, 0, 8'h96, 6);
    add(0, 1, 0, 0, 8'hA5, 1, 0, 8'h4B, 7);
    add(0, 1, 1, 0, 8'hA5, 1, 0, 8'hA5, 8);
    // commit + shift with loaded=1
    add(0, 1, 1, 1, 8'hA5, 1, 0, 8'hD2, 1);
    // premature commit while valid
    add(0, 0, 0, 1, 8'hA5, 1, 1, 8'hD2, 1);
    // 16 shifts: eight ones then eight zeros
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hE9, 2);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hF4, 3);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hFA, 4);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hFD, 5);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hFE, 6);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hFF, 7);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hFF, 8);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hFF, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h7F, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h3F, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h1F, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h0F, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h07, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h03, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h01, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h00, 8);
    // five shifts of a new pattern, then async reset
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'h80, 8);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'hC0, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h60, 8);
    add(0, 1, 0, 0, 8'hA5, 1, 1, 8'h30, 8);
    add(0, 1, 1, 0, 8'hA5, 1, 1, 8'h98, 8);
    add(1, 0, 0, 0, 8'h3C, 0, 0, 8'h00, 0);
    // commit + shift with loaded=0
    add(0, 1, 1, 1, 8'h3C, 0, 1, 8'h80, 1);
    add(1, 0, 0, 0, 8'h3C, 0, 0, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // reset held across an edge with shift and commit pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      shift_en  = 1'b1;
      ccff_head = 1'b1;
    end
    @(negedge clk);
    pReset = 1'b1;
    commit = 1'b1;
    @(posedge clk);
    #1;
    h.e_out = 8'h3C; h.e_v = 1'b0; h.e_err = 1'b0;
    h.e_sh = 8'h00; h.e_cnt = 4'd0;
    check(h, 100);
    @(negedge clk);
    pReset   = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    @(posedge clk);
    #1;
    check(h, 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/const_bank.md
CONST_BANK -- requirements
Module: const_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of constant outputs; legal range is 1..64.
REQ-002 The block SHALL have parameter RESET_VAL, default all-zeros, meaning the WIDTH-bit value driven on const_out after reset.
REQ-003 The block SHALL have port prog_clk, input, 1 bit: the single configuration clock.
REQ-004 The block SHALL have port pReset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ccff_head, input, 1 bit: serial configuration data in.
REQ-006 The block SHALL have port shift_en, input, 1 bit: shifts ccff_head into the chain this cycle.
REQ-007 The block SHALL have port commit, input, 1 bit: request to transfer the shadow chain to const_out.
REQ-008 The block SHALL have port const_out, output, WIDTH bits: registered tie-off constants to the fabric.
REQ-009 The block SHALL have port ccff_tail, output, 1 bit: serial data out to the next chain element, equal to shadow bit 0.
REQ-010 The block SHALL have port loaded, output, 1 bit: high when WIDTH shifts have occurred since the last reset or accepted commit.
REQ-011 The block SHALL have port cfg_valid, output, 1 bit: high when const_out holds a committed value rather than RESET_VAL.
REQ-012 The block SHALL have port commit_err, output, 1 bit: sticky flag set by a commit received while loaded is low.

Function
REQ-013 On shift_en, shadow SHALL become {ccff_head, shadow[WIDTH-1:1]}, so the first bit shifted in lands in bit 0 after WIDTH shifts.
REQ-014 Shift count SHALL increment by one per shift_en, saturate at WIDTH, and be clog2(WIDTH+1) bits wide.
REQ-015 loaded SHALL equal (count == WIDTH), combinational from the count register.
REQ-016 Commit with loaded=1 SHALL load const_out with the pre-edge shadow value on the same prog_clk edge.
REQ-017 The same edge SHALL set cfg_valid and clear count to 0; output latency from commit to const_out is one edge.
REQ-018 Commit with loaded=0 SHALL leave const_out, cfg_valid and count unchanged and SHALL set commit_err.
REQ-019 commit_err SHALL clear only on pReset.
REQ-020 For simultaneous commit and shift_en with loaded=1, const_out SHALL take the pre-shift shadow, shadow SHALL shift, and count SHALL become 1.
REQ-021 For simultaneous commit and shift_en with loaded=0, the shift SHALL proceed normally and commit_err SHALL be set.
REQ-022 const_out SHALL change only on an accepted commit or on reset, never during shifting, so the fabric sees no glitches.
REQ-023 Extra shifts past WIDTH SHALL keep shifting shadow, with ccff_tail forwarding data, while count stays saturated.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from an input to an output, except loaded, which decodes count only.

Reset
REQ-025 pReset SHALL asynchronously set const_out=RESET_VAL, shadow=0, count=0, cfg_valid=0 and commit_err=0.
REQ-026 While reset is asserted, ccff_tail SHALL be 0 and loaded SHALL be 0.
REQ-027 Reset asserted mid-shift or coincident with commit SHALL win; the partial load SHALL be discarded.
REQ-028 Release of pReset SHALL be synchronised to prog_clk by the integrator; the block SHALL NOT contain its own synchroniser.

Structure
REQ-029 The shared fabric package SHALL hold the CONST_BANK_MAX_WIDTH=64 constant and the count-width function used for the counter width.
REQ-030 The shift chain with its counter SHALL be one sub-module, const_bank_chain; commit logic and output registers SHALL reside in const_bank.
REQ-031 With WIDTH=1 and RESET_VAL=0, the block SHALL be a drop-in superset of the single fixed-zero tie cell.

Verification
REQ-032 With WIDTH=8, reset then shift bits 1,0,1,0,0,1,0,1 followed by commit, the bench SHALL see const_out=0xA5, cfg_valid=1 and loaded=0 on the next edge.
REQ-033 With RESET_VAL=0x3C, after reset and a commit after only 3 shifts, the bench SHALL see const_out=0x3C, cfg_valid=0, commit_err=1 and count=3.
REQ-034 With shadow=0xA5 and loaded=1, commit plus shift_en with ccff_head=1 SHALL give const_out=0xA5, shadow=0xD2 and count=1.
REQ-035 Asserting pReset asynchronously after 5 shifts of a new pattern (const_out=0xA5) SHALL give const_out=RESET_VAL immediately and count=0, with commit_err cleared.
REQ-036 Running 16 shifts of pattern 0xFF then 0x00 SHALL give ccff_tail=1 on shifts 9..16 and loaded held at 1, while const_out does not change.
